// File: rtl/uart_baud_tick_gen.sv
// Purpose: programmable UART baud timing - oversample strobe, bit strobe and bit-rate square wave.
// Latency: outputs are registered; os_tick rises `period` clks after the first enabled edge.
// Backpressure: none; en=0 freezes the counters, and div_load is always accepted (div_in==0 is rejected via cfg_err).
//
// Optional feature macro: BAUD_FRAC_EN (fractional divisor in 1/16 clk steps).
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   en        count enable; low freezes cnt/os_cnt/bclk/frac_acc, no ticks
//   sync      phase realign pulse: clears cnt/os_cnt/bclk/frac_acc, no tick that cycle
//   div_in    new divisor in clk cycles per os_tick
//   frac_in   new fractional divisor in 1/16 clk units (used only with BAUD_FRAC_EN)
//   div_load  one-cycle strobe capturing div_in/frac_in into the pending slot
//   os_tick   one-clk pulse every period clks
//   bit_tick  one-clk pulse coincident with every OVERSAMPLE-th os_tick
//   bclk      50% duty square wave at the bit rate
//   cfg_err   one-clk pulse when a div_load with div_in==0 is rejected
module uart_baud_tick_gen #(
  parameter int CLKF       = 1_600_000,
  parameter int BR         = 10_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic [DIV_W-1:0] div_in,
  input  logic [3:0]       frac_in,
  input  logic             div_load,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             bclk,
  output logic             cfg_err
);

  // Guarded so an illegal parameter set reaches the $fatal below instead of dividing by zero.
  localparam longint DIV_RST_L = (CLKF == 0 || BR == 0 || OVERSAMPLE < 2) ? 64'sd0 :
                                 longint'(CLKF) / (longint'(BR) * longint'(OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_L);
  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W:0]  ONE_P   = (DIV_W+1)'(1);

  if (CLKF == 0 || BR == 0 || OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0 ||
      DIV_RST_L == 0 || DIV_RST_L >= (64'sd1 <<< DIV_W)) begin : g_bad_cfg
    $fatal(1, "uart_baud_tick_gen: illegal parameter set");
  end

  logic [DIV_W-1:0] cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             pend_vld;
  logic [DIV_W:0]   period;
  logic             wrap;

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_act;
  logic [3:0] frac_pend;
  logic [3:0] frac_acc;
  logic [4:0] frac_sum;

  // The carry of the accumulation performed at this period's wrap stretches
  // this same period, so frac=8 gives 10,11,10,11... after the first period.
  assign frac_sum = {1'b0, frac_acc} + {1'b0, frac_act};
  assign period   = {1'b0, div_act} + {{DIV_W{1'b0}}, frac_sum[4]};
`else
  logic unused_frac;
  assign unused_frac = ^frac_in;
  assign period      = {1'b0, div_act};
`endif

  // >= rather than == so a divisor shrunk while frozen (en=0) cannot leave
  // cnt stranded above the new terminal count.
  assign wrap = ({1'b0, cnt} >= (period - ONE_P));

  always_ff @(posedge clk) begin
    if (reset) begin
      os_tick   <= 1'b0;
      bit_tick  <= 1'b0;
      bclk      <= 1'b0;
      cfg_err   <= 1'b0;
      cnt       <= '0;
      os_cnt    <= '0;
      div_act   <= DIV_RST;
      div_pend  <= DIV_RST;
      pend_vld  <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_act  <= 4'd0;
      frac_pend <= 4'd0;
      frac_acc  <= 4'd0;
`endif
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      cfg_err  <= div_load && (div_in == '0);

      // Apply a pending divisor only at a period boundary (or when the
      // counter is not running), so the in-flight period keeps its length.
      if (pend_vld && (sync || !en || wrap)) begin
        div_act  <= div_pend;
        pend_vld <= 1'b0;
`ifdef BAUD_FRAC_EN
        frac_act <= frac_pend;
`endif
      end

      // A load in the same cycle lands in the pending slot and waits for the
      // following wrap; a later load overwrites an earlier unapplied one.
      if (div_load && (div_in != '0)) begin
        div_pend <= div_in;
        pend_vld <= 1'b1;
`ifdef BAUD_FRAC_EN
        frac_pend <= frac_in;
`endif
      end

      if (sync) begin
        cnt    <= '0;
        os_cnt <= '0;
        bclk   <= 1'b0;
`ifdef BAUD_FRAC_EN
        frac_acc <= 4'd0;
`endif
      end else if (en) begin
        if (wrap) begin
          cnt     <= '0;
          os_tick <= 1'b1;
`ifdef BAUD_FRAC_EN
          frac_acc <= frac_sum[3:0];
`endif
          if (os_cnt == OS_LAST) begin
            os_cnt   <= '0;
            bit_tick <= 1'b1;
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
          if (os_cnt == OS_HALF || os_cnt == OS_LAST) begin
            bclk <= ~bclk;
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
module tb_uart_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        sync = 1'b0;
  logic [15:0] div_in = 16'd0;
  logic [3:0]  frac_in = 4'd0;
  logic        div_load = 1'b0;
  logic        os_tick, bit_tick, bclk, cfg_err;

  always #5 clk = ~clk;

  uart_baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .div_in   (div_in),
    .frac_in  (frac_in),
    .div_load (div_load),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .bclk     (bclk),
    .cfg_err  (cfg_err)
  );

  // Number of rising edges seen so far; a registered output sampled on the
  // following falling edge carries the index of the edge that produced it.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic bt;
    logic bc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  int   mon_c;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected tick number k counts os_ticks since os_cnt/bclk were last cleared.
  task automatic push_tick(input int c, input int k);
    exp_t e;
    e.c  = c;
    e.bt = (k % 16 == 0);
    e.bc = ((k / 8) % 2 == 1);
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int first_c, input int per, input int n, input int k0);
    for (int i = 0; i < n; i++) push_tick(first_c + i * per, k0 + i);
  endtask

  // Returns #1 after rising edge number c.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_os_tick"}, int'(os_tick), 0);
    chk({tag, "_bit_tick"}, int'(bit_tick), 0);
    chk({tag, "_bclk"}, int'(bclk), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  // Two reset edges, idle and scoreboard-drained checks, then release.
  // b is the last reset edge; the first counting edge is b+1.
  task automatic phase_reset(output int b);
    reset = 1'b1; en = 1'b1; sync = 1'b0; div_load = 1'b0;
    div_in = 16'd0; frac_in = 4'd0;
    wait_cyc(cyc + 2);
    check_idle("reset");
    chk("ticks_outstanding", exp_q.size(), 0);
    chk("cfg_err_outstanding", err_q.size(), 0);
    exp_q.delete();
    err_q.delete();
    reset = 1'b0;
    b = cyc;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (os_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_os_tick_cycle", cyc, -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("os_tick_cycle", cyc, mon_e.c);
        chk("bit_tick_at_tick", int'(bit_tick), int'(mon_e.bt));
        chk("bclk_at_tick", int'(bclk), int'(mon_e.bc));
      end
    end else if (bit_tick === 1'b1) begin
      chk("bit_tick_without_os_tick", 1, 0);
    end
    if (cfg_err === 1'b1) begin
      if (err_q.size() == 0) begin
        chk("unexpected_cfg_err_cycle", cyc, -1);
      end else begin
        mon_c = err_q.pop_front();
        chk("cfg_err_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    int b;
    int s;
    int c;

    // 1: free run at the power-up divisor of 10 for 400 clks.
    phase_reset(b);
    push_run(b + 10, 10, 40, 1);
    wait_cyc(b + 400);

    // 2: reload to 4 while cnt=3; the current period still ends at 10.
    phase_reset(b);
    push_tick(b + 10, 1);
    push_run(b + 14, 4, 9, 2);
    wait_cyc(b + 3);
    div_in = 16'd4; div_load = 1'b1;
    wait_cyc(b + 4);
    div_load = 1'b0;
    wait_cyc(b + 46);

    // 3: zero divisor rejected, then divisor 1 gives a continuous os_tick.
    phase_reset(b);
    push_run(b + 10, 10, 6, 1);
    push_run(b + 61, 1, 20, 7);
    err_q.push_back(b + 4);
    wait_cyc(b + 3);
    div_in = 16'd0; div_load = 1'b1;
    wait_cyc(b + 4);
    div_load = 1'b0;
    wait_cyc(b + 50);
    div_in = 16'd1; div_load = 1'b1;
    wait_cyc(b + 51);
    div_load = 1'b0;
    wait_cyc(b + 80);

    // 4: sync while os_cnt=7, then a 25-clk enable gap.
    phase_reset(b);
    push_run(b + 10, 10, 7, 1);
    push_run(b + 84, 10, 3, 1);
    push_run(b + 139, 10, 14, 4);
    wait_cyc(b + 73);
    sync = 1'b1;
    wait_cyc(b + 74);
    sync = 1'b0;
    chk("sync_bclk", int'(bclk), 0);
    wait_cyc(b + 106);
    en = 1'b0;
    wait_cyc(b + 120);
    chk("frozen_os_tick", int'(os_tick), 0);
    wait_cyc(b + 131);
    en = 1'b1;
    wait_cyc(b + 269);

    // 5: divisor 10 + 8/16 loaded while stopped, so it applies at once.
    phase_reset(b);
    en = 1'b0; div_in = 16'd10; frac_in = 4'd8; div_load = 1'b1;
    wait_cyc(b + 1);
    div_load = 1'b0;
    wait_cyc(b + 2);
    en = 1'b1;
    s = b + 2;
    c = s;
    for (int i = 1; i <= 16; i++) begin
`ifdef BAUD_FRAC_EN
      c = s + 10 * i + i / 2;
`else
      c = s + 10 * i;
`endif
      push_tick(c, i);
    end
    wait_cyc(c);
`ifdef BAUD_FRAC_EN
    chk("frac_span_16_ticks", c - s, 168);
`else
    chk("span_16_ticks", c - s, 160);
`endif

    // 6: reset at cnt=5 with a load of 4 pending; divisor must revert to 10.
    phase_reset(b);
    wait_cyc(b + 1);
    div_in = 16'd4; div_load = 1'b1;
    wait_cyc(b + 2);
    div_load = 1'b0;
    wait_cyc(b + 5);
    reset = 1'b1;
    wait_cyc(b + 6);
    check_idle("reset_mid");
    reset = 1'b0;
    push_run(b + 16, 10, 3, 1);
    wait_cyc(b + 36);

    phase_reset(b);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
